// File: rtl/mac_feed_seq.sv
// Purpose : sequences one MAC_10xINT8 from a valid/ready beat stream and returns
//           each group's accumulated result on a valid/ready result port.
// Latency : beat load 1 cycle after acceptance, feed 2 cycles after; result valid
//           MAC_LAT+2 cycles after the group's last beat is accepted.
// Backpr. : s_ready drops from last-beat acceptance until the result is taken.
// Ports   : i_clk/i_clr            clock, synchronous active-high reset
//           i_s_* / o_s_ready      input beat stream (data, weight, last)
//           o_ena, o_data_in, o_cascade_weight_in, o_load_bb_a/b,
//           o_load_buf_sel, o_feed_sel, o_zero_en   MAC control/data
//           i_result_h/l           MAC result
//           o_res_valid/i_res_ready/o_res_data      captured group result
//           o_beat_cnt             beats in the current/last group (saturating)
module mac_feed_seq #(
  parameter int DATAW    = 8,
  parameter int VECTOR_W = 10,
  parameter int MAC_LAT  = 4,
  parameter int CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_s_valid,
  output logic             o_s_ready,
  input  logic [95:0]      i_s_data,
  input  logic [87:0]      i_s_weight,
  input  logic             i_s_last,
  output logic             o_ena,
  output logic [95:0]      o_data_in,
  output logic [87:0]      o_cascade_weight_in,
  output logic             o_load_bb_a,
  output logic             o_load_bb_b,
  output logic             o_load_buf_sel,
  output logic [1:0]       o_feed_sel,
  output logic             o_zero_en,
  input  logic [36:0]      i_result_h,
  input  logic [37:0]      i_result_l,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [74:0]      o_res_data,
  output logic [CNT_W-1:0] o_beat_cnt
);

  localparam int         VEC_BITS  = DATAW * VECTOR_W;
  // One cycle from acceptance to feed, MAC_LAT to result, one to capture.
  localparam logic [7:0] DRAIN_CNT = 8'(MAC_LAT + 2);

  typedef enum logic [1:0] {
    ST_STREAM = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;
  logic             w_capture;
  logic             w_accept;
  logic             w_hold_exit;
  logic             w_s_ready;
  logic [95:0]      w_data_fwd;
  logic [87:0]      w_weight_fwd;

  logic             r_ena;
  logic             r_wr_sel;
  logic             r_first;
  logic             r_s1_first;
  logic [95:0]      r_data_in;
  logic [87:0]      r_weight;
  logic             r_load_a;
  logic             r_load_b;
  logic             r_load_buf_sel;
  logic [1:0]       r_feed_sel;
  logic             r_zero_en;
  logic             r_res_valid;
  logic [74:0]      r_res_data;
  logic [CNT_W-1:0] r_beat_cnt;

  // r_ena gates s_ready so that every output reads 0 while in reset.
  assign w_s_ready   = r_ena && (r_state == ST_STREAM);
  assign w_accept    = i_s_valid && w_s_ready;
  assign w_hold_exit = (r_state == ST_HOLD) && i_res_ready;

  // Vector field plus the pass-through bits above it, forwarded as-is.
  assign w_data_fwd   = {i_s_data[95:VEC_BITS], i_s_data[VEC_BITS-1:0]};
  assign w_weight_fwd = {i_s_weight[87:VEC_BITS], i_s_weight[VEC_BITS-1:0]};

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= ST_STREAM;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      ST_STREAM: begin
        if (w_accept && i_s_last) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = DRAIN_CNT;
        end
      end
      ST_DRAIN: begin
        w_cnt_nxt = r_cnt - 8'd1;
        if (r_cnt == 8'd1) begin
          w_state_nxt = ST_HOLD;
          w_capture   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_res_ready) w_state_nxt = ST_STREAM;
      end
      default: w_state_nxt = ST_STREAM;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_ena          <= 1'b0;
      r_wr_sel       <= 1'b0;
      r_first        <= 1'b1;
      r_s1_first     <= 1'b0;
      r_data_in      <= '0;
      r_weight       <= '0;
      r_load_a       <= 1'b0;
      r_load_b       <= 1'b0;
      r_load_buf_sel <= 1'b0;
      r_feed_sel     <= 2'b00;
      r_zero_en      <= 1'b0;
      r_res_valid    <= 1'b0;
      r_res_data     <= '0;
      r_beat_cnt     <= '0;
    end else begin
      r_ena <= 1'b1;

      // Load stage: write the idle half of the ping-pong buffer.
      r_load_a <= w_accept && !r_wr_sel;
      r_load_b <= w_accept && r_wr_sel;
      if (w_accept) begin
        r_data_in  <= w_data_fwd;
        r_weight   <= w_weight_fwd;
        r_wr_sel   <= !r_wr_sel;
        r_s1_first <= r_first;
        r_first    <= 1'b0;
        if (r_first)
          r_beat_cnt <= CNT_W'(1);
        else if (r_beat_cnt != {CNT_W{1'b1}})
          r_beat_cnt <= r_beat_cnt + CNT_W'(1);
      end
      // No beat can be accepted in HOLD, so this never races the clear above.
      if (w_hold_exit) r_first <= 1'b1;

      // Feed stage: the buffer loaded last cycle drives the dot product now.
      if (r_load_a || r_load_b) begin
        r_load_buf_sel <= r_load_b;
        r_feed_sel     <= r_load_b ? 2'b10 : 2'b01;
        r_zero_en      <= r_s1_first;
      end else begin
        r_feed_sel <= 2'b00;
        r_zero_en  <= 1'b0;
      end

      if (w_capture) begin
        r_res_data  <= {i_result_h, i_result_l};
        r_res_valid <= 1'b1;
      end else if (w_hold_exit) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign o_s_ready           = w_s_ready;
  assign o_ena               = r_ena;
  assign o_data_in           = r_data_in;
  assign o_cascade_weight_in = r_weight;
  assign o_load_bb_a         = r_load_a;
  assign o_load_bb_b         = r_load_b;
  assign o_load_buf_sel      = r_load_buf_sel;
  assign o_feed_sel          = r_feed_sel;
  assign o_zero_en           = r_zero_en;
  assign o_res_valid         = r_res_valid;
  assign o_res_data          = r_res_data;
  assign o_beat_cnt          = r_beat_cnt;

endmodule

// File: tb/tb_mac_feed_seq.sv
// Bench for mac_feed_seq paired with a behavioural MAC_10xINT8:
// ping-pong buffers, accumulator cleared by zero_en, MAC_LAT=4 result latency.
// Directed scenarios with hand-computed expected values.
module tb_mac_feed_seq;

  logic        clk = 1'b0;
  logic        clr;
  logic        s_valid;
  logic        s_ready;
  logic [95:0] s_data;
  logic [87:0] s_weight;
  logic        s_last;
  logic        ena;
  logic [95:0] data_in;
  logic [87:0] cascade_weight_in;
  logic        load_bb_a;
  logic        load_bb_b;
  logic        load_buf_sel;
  logic [1:0]  feed_sel;
  logic        zero_en;
  logic [36:0] result_h;
  logic [37:0] result_l;
  logic        res_valid;
  logic        res_ready;
  logic [74:0] res_data;
  logic [15:0] beat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [95:0] d1, d2, dones;
  logic [87:0] w1, w2, wones;

  mac_feed_seq #(.DATAW(8), .VECTOR_W(10), .MAC_LAT(4), .CNT_W(16)) dut (
    .i_clk               (clk),
    .i_clr               (clr),
    .i_s_valid           (s_valid),
    .o_s_ready           (s_ready),
    .i_s_data            (s_data),
    .i_s_weight          (s_weight),
    .i_s_last            (s_last),
    .o_ena               (ena),
    .o_data_in           (data_in),
    .o_cascade_weight_in (cascade_weight_in),
    .o_load_bb_a         (load_bb_a),
    .o_load_bb_b         (load_bb_b),
    .o_load_buf_sel      (load_buf_sel),
    .o_feed_sel          (feed_sel),
    .o_zero_en           (zero_en),
    .i_result_h          (result_h),
    .i_result_l          (result_l),
    .o_res_valid         (res_valid),
    .i_res_ready         (res_ready),
    .o_res_data          (res_data),
    .o_beat_cnt          (beat_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural MAC ----------------
  logic [95:0]        m_bufa_d = '0, m_bufb_d = '0;
  logic [87:0]        m_bufa_w = '0, m_bufb_w = '0;
  logic signed [74:0] m_acc = '0, m_p1 = '0, m_p2 = '0, m_p3 = '0;

  function automatic logic signed [74:0] dot(input logic [95:0] d, input logic [87:0] w);
    logic signed [74:0] s;
    logic signed [7:0]  a, b;
    s = '0;
    for (int i = 0; i < 10; i++) begin
      a = d[i*8 +: 8];
      b = w[i*8 +: 8];
      s = s + a * b;
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (feed_sel == 2'b01)
      m_acc <= (zero_en ? 75'sd0 : m_acc) + dot(m_bufa_d, m_bufa_w);
    else if (feed_sel == 2'b10)
      m_acc <= (zero_en ? 75'sd0 : m_acc) + dot(m_bufb_d, m_bufb_w);
    if (load_bb_a) begin
      m_bufa_d <= data_in;
      m_bufa_w <= cascade_weight_in;
    end
    if (load_bb_b) begin
      m_bufb_d <= data_in;
      m_bufb_w <= cascade_weight_in;
    end
    m_p1 <= m_acc;
    m_p2 <= m_p1;
    m_p3 <= m_p2;
  end

  assign result_h = m_p3[74:38];
  assign result_l = m_p3[37:0];

  // ---------------- stimulus helpers ----------------
  function automatic logic [95:0] mkd(input int base, input int step, input logic [15:0] top);
    logic [95:0] v;
    v = '0;
    v[95:80] = top;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(base + step * i);
    return v;
  endfunction

  function automatic logic [87:0] mkw(input int base, input int step, input logic [7:0] top);
    logic [87:0] v;
    v = '0;
    v[87:80] = top;
    for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'(base + step * i);
    return v;
  endfunction

  // Counts falling edges until res_valid is seen; 40 means it never came.
  task automatic wait_res(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (res_valid !== 1'b1 && n < 40);
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clr = 1'b1; s_valid = 1'b0; s_last = 1'b0; res_ready = 1'b0;
    s_data = '0; s_weight = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (ena !== 1'b0) begin n_fail++; $display("FAIL reset_ena: got %b want 0", ena); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_checks++; if ({load_bb_a, load_bb_b, feed_sel, zero_en, load_buf_sel, res_valid} !== 7'b0) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 0", {load_bb_a, load_bb_b, feed_sel, zero_en, load_buf_sel, res_valid});
    end
    n_checks++; if (beat_cnt !== 16'd0 || res_data !== 75'd0) begin
      n_fail++; $display("FAIL reset_cnt_data: got %0d/%0h want 0/0", beat_cnt, res_data);
    end
    clr = 1'b0;
    @(negedge clk);
    n_checks++; if (ena !== 1'b1 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release: ena/s_ready got %b%b want 11", ena, s_ready);
    end
  endtask

  task automatic test_single_a();
    int n;
    s_data = d1; s_weight = w1; s_last = 1'b1; s_valid = 1'b1;
    n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready: got %b want 1", s_ready); end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    n_checks++; if (load_bb_a !== 1'b1 || load_bb_b !== 1'b0) begin
      n_fail++; $display("FAIL t1_load: a/b got %b%b want 10", load_bb_a, load_bb_b);
    end
    n_checks++; if (data_in !== d1 || cascade_weight_in !== w1) begin
      n_fail++; $display("FAIL t1_fwd: got %h/%h want %h/%h", data_in, cascade_weight_in, d1, w1);
    end
    @(negedge clk);
    n_checks++; if (feed_sel !== 2'b01 || zero_en !== 1'b1 || load_buf_sel !== 1'b0 || load_bb_a !== 1'b0) begin
      n_fail++; $display("FAIL t1_feed: feed/zero/sel/lda got %b/%b/%b/%b want 01/1/0/0", feed_sel, zero_en, load_buf_sel, load_bb_a);
    end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL t1_drain_ready: got %b want 0", s_ready); end
    wait_res(n);
    // res_valid rises on the 6th clock edge after the accepting edge.
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL t1_latency: got %0d want 5", n); end
    n_checks++; if (res_data !== 75'd220) begin n_fail++; $display("FAIL t1_res: got %0d want 220", res_data); end
    n_checks++; if (beat_cnt !== 16'd1) begin n_fail++; $display("FAIL t1_cnt: got %0d want 1", beat_cnt); end
    release_res();
    n_checks++; if (res_valid !== 1'b0 || s_ready !== 1'b1) begin
      n_fail++; $display("FAIL t1_release: valid/ready got %b%b want 01", res_valid, s_ready);
    end
  endtask

  task automatic test_single_b();
    int n;
    s_data = d2; s_weight = w2; s_last = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    n_checks++; if (load_bb_a !== 1'b0 || load_bb_b !== 1'b1) begin
      n_fail++; $display("FAIL t2_load: a/b got %b%b want 01", load_bb_a, load_bb_b);
    end
    @(negedge clk);
    n_checks++; if (feed_sel !== 2'b10 || zero_en !== 1'b1 || load_buf_sel !== 1'b1) begin
      n_fail++; $display("FAIL t2_feed: feed/zero/sel got %b/%b/%b want 10/1/1", feed_sel, zero_en, load_buf_sel);
    end
    wait_res(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL t2_latency: got %0d want 5", n); end
    n_checks++; if (res_data !== 75'd45) begin n_fail++; $display("FAIL t2_res: got %0d want 45", res_data); end
    release_res();
  endtask

  // Leaves the DUT holding its result for test_hold.
  task automatic test_back_to_back();
    int n;
    s_data = d1; s_weight = w1; s_last = 1'b0; s_valid = 1'b1;
    @(negedge clk);
    s_data = d2; s_weight = w2; s_last = 1'b1;
    n_checks++; if (load_bb_a !== 1'b1 || load_bb_b !== 1'b0) begin
      n_fail++; $display("FAIL t3_load1: a/b got %b%b want 10", load_bb_a, load_bb_b);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    n_checks++; if (load_bb_b !== 1'b1 || feed_sel !== 2'b01 || zero_en !== 1'b1) begin
      n_fail++; $display("FAIL t3_overlap: ldb/feed/zero got %b/%b/%b want 1/01/1", load_bb_b, feed_sel, zero_en);
    end
    @(negedge clk);
    n_checks++; if (feed_sel !== 2'b10 || zero_en !== 1'b0 || load_bb_b !== 1'b0) begin
      n_fail++; $display("FAIL t3_feed2: feed/zero/ldb got %b/%b/%b want 10/0/0", feed_sel, zero_en, load_bb_b);
    end
    wait_res(n);
    n_checks++; if (n !== 5) begin n_fail++; $display("FAIL t3_latency: got %0d want 5", n); end
    n_checks++; if (res_data !== 75'd265) begin n_fail++; $display("FAIL t3_res: got %0d want 265", res_data); end
    n_checks++; if (beat_cnt !== 16'd2) begin n_fail++; $display("FAIL t3_cnt: got %0d want 2", beat_cnt); end
  endtask

  task automatic test_hold();
    int bad;
    bad = 0;
    s_data = d1; s_weight = w1; s_last = 1'b0; s_valid = 1'b1;  // must be refused
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (s_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 75'd265 ||
          load_bb_a !== 1'b0 || load_bb_b !== 1'b0 || beat_cnt !== 16'd2) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL t4_hold_stable: got %0d bad cycles want 0", bad); end
    s_valid = 1'b0;
    release_res();
    n_checks++; if (s_ready !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL t4_release: ready/valid got %b%b want 10", s_ready, res_valid);
    end
  endtask

  task automatic test_gapped_stream();
    logic [11:0] pat;
    logic        a1, s1, f1, a2, s2, f2, v, s0, f0, exp_sel;
    int          sent, bad, n;
    pat = 12'b0010_0100_1101;  // bit c = s_valid on cycle c; five beats
    a1 = 0; s1 = 0; f1 = 0; a2 = 0; s2 = 0; f2 = 0;
    exp_sel = 1'b0;  // four beats accepted so far
    sent = 0; bad = 0;
    s_data = dones; s_weight = wones;
    for (int c = 0; c < 14; c++) begin
      if (load_bb_a !== (a1 & ~s1) || load_bb_b !== (a1 & s1)) bad++;
      if (feed_sel !== (a2 ? (s2 ? 2'b10 : 2'b01) : 2'b00) || zero_en !== (a2 & f2)) bad++;
      v = (c < 12) ? pat[c] : 1'b0;
      s_valid = v;
      s_last = v && (sent == 4);
      f0 = v && (sent == 0);
      s0 = exp_sel;
      if (v) begin
        sent++;
        exp_sel = ~exp_sel;
      end
      a2 = a1; s2 = s1; f2 = f1;
      a1 = v;  s1 = s0; f1 = f0;
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL t5_strobes: got %0d bad cycles want 0", bad); end
    wait_res(n);
    n_checks++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL t5_timeout: res_valid got %b want 1", res_valid); end
    n_checks++; if (res_data !== 75'd50) begin n_fail++; $display("FAIL t5_res: got %0d want 50", res_data); end
    n_checks++; if (beat_cnt !== 16'd5) begin n_fail++; $display("FAIL t5_cnt: got %0d want 5", beat_cnt); end
    release_res();
  endtask

  task automatic test_clr_in_drain();
    int n, seen;
    s_data = d1; s_weight = w1; s_last = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    n_checks++; if ({ena, s_ready, load_bb_a, load_bb_b, feed_sel, zero_en, load_buf_sel, res_valid} !== 9'b0) begin
      n_fail++; $display("FAIL t6_clr_ctrl: got %b want 0", {ena, s_ready, load_bb_a, load_bb_b, feed_sel, zero_en, load_buf_sel, res_valid});
    end
    n_checks++; if (data_in !== 96'd0 || cascade_weight_in !== 88'd0 || res_data !== 75'd0 || beat_cnt !== 16'd0) begin
      n_fail++; $display("FAIL t6_clr_data: got %h/%h/%h/%0d want 0", data_in, cascade_weight_in, res_data, beat_cnt);
    end
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL t6_no_result: got %0d valid cycles want 0", seen); end
    s_data = d2; s_weight = w2; s_last = 1'b1; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    n_checks++; if (load_bb_a !== 1'b1 || load_bb_b !== 1'b0) begin
      n_fail++; $display("FAIL t6_load: a/b got %b%b want 10", load_bb_a, load_bb_b);
    end
    @(negedge clk);
    n_checks++; if (feed_sel !== 2'b01 || zero_en !== 1'b1) begin
      n_fail++; $display("FAIL t6_feed: feed/zero got %b/%b want 01/1", feed_sel, zero_en);
    end
    wait_res(n);
    n_checks++; if (res_data !== 75'd45 || beat_cnt !== 16'd1) begin
      n_fail++; $display("FAIL t6_res: got %0d/%0d want 45/1", res_data, beat_cnt);
    end
    release_res();
  endtask

  initial begin
    d1    = mkd(1, 1, 16'hA5C3);
    w1    = mkw(10, -1, 8'h5A);
    d2    = mkd(-5, 1, 16'h0F0F);
    w2    = mkw(3, 1, 8'hC3);
    dones = '1;
    wones = '1;
    test_reset();
    test_single_a();
    test_single_b();
    test_back_to_back();
    test_hold();
    test_gapped_stream();
    test_clr_in_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
